// File: rtl/bios_link_master.sv
// Host-side master for a byte-serial BIOS link: serialises BOOT/RST/NOP/READ/WRITE
// requests into opcode byte sequences, caching the address halves to skip redundant prefixes.
module bios_link_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [7:0]  i_req_data,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_out_ready,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_in_ready,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_booted
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_BOOT  = 3'd1,
    OP_RST   = 3'd2,
    OP_READ  = 3'd3,
    OP_WRITE = 3'd4
  } op_e;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, BOOTED} state_e;

  localparam logic [7:0] BYTE_ADR_LOWER = 8'h05;
  localparam logic [7:0] BYTE_ADR_UPPER = 8'h06;

  state_e      state_q, state_d;
  logic [7:0]  buf_q [8];
  logic [7:0]  build_buf [8];
  logic [3:0]  build_count;
  logic [3:0]  idx_q, count_q;
  logic [2:0]  op_q;
  logic [TW-1:0] timer_q;
  logic        hi_valid_q, lo_valid_q;
  logic [15:0] hi_q, lo_q;
  logic        need_hi, need_lo, is_rw;
  logic        accept, last_beat, got_rsp, timeout;
  logic        rsp_valid_q, rsp_err_q;
  logic [7:0]  rsp_data_q;

  assign is_rw   = (i_req_op == OP_READ) || (i_req_op == OP_WRITE);
  assign need_hi = !hi_valid_q || (hi_q != i_req_addr[31:16]);
  assign need_lo = !lo_valid_q || (lo_q != i_req_addr[15:0]);

  // Command assembly from the live request and the current address cache.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    build_buf   = '{default: 8'h00};
    build_count = 4'd0;
    case (i_req_op)
      OP_NOP, OP_BOOT, OP_RST: begin
        build_buf[0] = {5'b0, i_req_op};
        build_count  = 4'd1;
      end
      OP_READ, OP_WRITE: begin
        if (need_hi) begin
          build_buf[0] = BYTE_ADR_LOWER;
          build_buf[1] = i_req_addr[31:24];
          build_buf[2] = i_req_addr[23:16];
          build_count  = 4'd3;
        end
        if (need_lo) begin
          build_buf[build_count[2:0]]        = BYTE_ADR_UPPER;
          build_buf[build_count[2:0] + 3'd1] = i_req_addr[15:8];
          build_buf[build_count[2:0] + 3'd2] = i_req_addr[7:0];
          build_count = build_count + 4'd3;
        end
        build_buf[build_count[2:0]] = {5'b0, i_req_op};
        build_count = build_count + 4'd1;
        if (i_req_op == OP_WRITE) begin
          build_buf[build_count[2:0]] = i_req_data;
          build_count = build_count + 4'd1;
        end
      end
      default: build_count = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    last_beat   = 1'b0;
    got_rsp     = 1'b0;
    timeout     = 1'b0;
    o_req_ready = (state_q == IDLE);
    o_valid     = (state_q == SEND);
    o_in_ready  = (state_q == WAIT_RSP);
    o_booted    = (state_q == BOOTED);
    o_data      = buf_q[idx_q[2:0]];
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          accept = 1'b1;
          if (build_count != 4'd0) state_d = SEND;
        end
      end
      SEND: begin
        if (i_out_ready && (idx_q == count_q - 4'd1)) begin
          last_beat = 1'b1;
          case (op_q)
            OP_READ: state_d = WAIT_RSP;
            OP_BOOT: state_d = BOOTED;
            default: state_d = IDLE;
          endcase
        end
      end
      WAIT_RSP: begin
        if (i_valid) begin
          got_rsp = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      BOOTED: state_d = BOOTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the byte buffer and cached address halves carry no reset; count and valid flags gate their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= build_buf;
      if (is_rw) begin
        hi_q <= i_req_addr[31:16];
        lo_q <= i_req_addr[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    rsp_valid_q <= 1'b0;
    rsp_err_q   <= 1'b0;
    rsp_data_q  <= 8'h00;
    if (rst) begin
      hi_valid_q <= 1'b0;
      lo_valid_q <= 1'b0;
      idx_q      <= 4'd0;
      count_q    <= 4'd0;
      timer_q    <= '0;
      op_q       <= 3'd0;
    end else begin
      if (accept) begin
        count_q <= build_count;
        idx_q   <= 4'd0;
        op_q    <= i_req_op;
        if (is_rw) begin
          hi_valid_q <= 1'b1;
          lo_valid_q <= 1'b1;
        end
      end
      if (state_q == SEND && i_out_ready) begin
        idx_q <= last_beat ? 4'd0 : idx_q + 4'd1;
        if (last_beat) timer_q <= '0;
      end
      if (state_q == WAIT_RSP) begin
        timer_q <= timer_q + 1'b1;
        if (got_rsp) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= i_data;
        end else if (timeout) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          hi_valid_q  <= 1'b0;
          lo_valid_q  <= 1'b0;
        end
      end
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bios_link_master.sv
// Directed bench for bios_link_master: byte sequences, address caching, stalls,
// read responses and timeout, BOOT terminal state and reset mid-command.
module tb_bios_link_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_req_op;
  logic [31:0] i_req_addr;
  logic [7:0]  i_req_data;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_out_ready;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_in_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_err;
  logic        o_booted;

  int checks   = 0;
  int failures = 0;

  bios_link_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_op   (i_req_op),
    .i_req_addr (i_req_addr),
    .i_req_data (i_req_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_out_ready(i_out_ready),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_in_ready (o_in_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_booted   (o_booted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns on the negedge after the accepting edge.
  task automatic send_req(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data);
    check("req_ready_before_req", {31'b0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_data  = data;
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  // Consume n bytes (first byte in bits 63:56) with i_out_ready following pat[cycle%4].
  task automatic stream(input string tag, input logic [63:0] bytes, input int n,
                        input logic [3:0] pat, input bit check_end);
    int k = 0;
    for (int cyc = 0; cyc < 4 * n + 8 && k < n; cyc++) begin
      i_out_ready = pat[cyc % 4];
      check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
      check({tag, "_byte"}, {24'b0, o_data}, {24'b0, bytes[63 - 8 * k -: 8]});
      if (i_out_ready) k++;
      @(negedge clk);
    end
    check({tag, "_count"}, k, n);
    i_out_ready = 1'b1;
    if (check_end) check({tag, "_valid_after"}, {31'b0, o_valid}, 32'd0);
  endtask

  task automatic check_idle_rsp(input string tag);
    check({tag, "_rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
    check({tag, "_rsp_err"},   {31'b0, o_rsp_err},   32'd0);
    check({tag, "_rsp_data"},  {24'b0, o_rsp_data},  32'd0);
  endtask

  initial begin
    rst = 1'b1; i_req_valid = 1'b0; i_req_op = 3'd0; i_req_addr = 32'd0; i_req_data = 8'd0;
    i_out_ready = 1'b1; i_data = 8'd0; i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_valid",     {31'b0, o_valid},     32'd0);
    check("rst_in_ready",  {31'b0, o_in_ready},  32'd0);
    check("rst_booted",    {31'b0, o_booted},    32'd0);
    check_idle_rsp("rst");

    // Cold cache: full prefix sequence
    send_req(3'd4, 32'h1234_5678, 8'hAB);
    stream("wr_full", 64'h05_12_34_06_56_78_04_AB, 8, 4'b1111, 1'b1);
    check("wr_full_idle", {31'b0, o_req_ready}, 32'd1);

    // Upper half cached: only lower prefix
    send_req(3'd4, 32'h1234_5679, 8'hCD);
    stream("wr_lo", 64'h06_56_79_04_CD_00_00_00, 5, 4'b1111, 1'b1);

    // Stray input byte while idle is ignored
    i_valid = 1'b1; i_data = 8'h99;
    check("stray_in_ready", {31'b0, o_in_ready}, 32'd0);
    @(negedge clk);
    i_valid = 1'b0;
    check_idle_rsp("stray");

    // Fully cached read, response on third WAIT_RSP cycle
    send_req(3'd3, 32'h1234_5679, 8'h00);
    stream("rd_hit", 64'h03_00_00_00_00_00_00_00, 1, 4'b1111, 1'b1);
    check("rd_in_ready", {31'b0, o_in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check_idle_rsp("rd_wait");
    i_valid = 1'b1; i_data = 8'h5A;
    @(negedge clk);
    i_valid = 1'b0;
    check("rd_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("rd_rsp_data",  {24'b0, o_rsp_data},  32'h5A);
    check("rd_rsp_err",   {31'b0, o_rsp_err},   32'd0);
    check("rd_back_idle", {31'b0, o_req_ready}, 32'd1);
    check("rd_in_ready_off", {31'b0, o_in_ready}, 32'd0);
    @(negedge clk);
    check_idle_rsp("rd_pulse_end");

    // Back-pressure 1,0,0,1 on a fresh address
    send_req(3'd4, 32'hA0B0_C0D0, 8'h77);
    stream("wr_stall", 64'h05_A0_B0_06_C0_D0_04_77, 8, 4'b1001, 1'b1);

    // Timeout after 16 cycles
    send_req(3'd3, 32'hA0B0_C0D0, 8'h00);
    stream("rd_to", 64'h03_00_00_00_00_00_00_00, 1, 4'b1111, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("to_waiting_in_ready", {31'b0, o_in_ready}, 32'd1);
      check("to_waiting_rsp", {31'b0, o_rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("to_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("to_rsp_err",   {31'b0, o_rsp_err},   32'd1);
    check("to_rsp_data",  {24'b0, o_rsp_data},  32'h00);
    check("to_idle",      {31'b0, o_req_ready}, 32'd1);
    @(negedge clk);
    check_idle_rsp("to_pulse_end");

    // Timeout cleared the cache: both prefixes again, immediate response
    send_req(3'd3, 32'hA0B0_C0D0, 8'h00);
    stream("rd_refill", 64'h05_A0_B0_06_C0_D0_03_00, 7, 4'b1111, 1'b0);
    i_valid = 1'b1; i_data = 8'h3C;
    @(negedge clk);
    i_valid = 1'b0;
    check("refill_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("refill_rsp_data",  {24'b0, o_rsp_data},  32'h3C);
    check("refill_rsp_err",   {31'b0, o_rsp_err},   32'd0);
    @(negedge clk);

    // Byte arriving in the expiry cycle wins
    send_req(3'd3, 32'hA0B0_C0D0, 8'h00);
    stream("rd_race", 64'h03_00_00_00_00_00_00_00, 1, 4'b1111, 1'b0);
    repeat (15) @(negedge clk);
    check("race_still_waiting", {31'b0, o_in_ready}, 32'd1);
    i_valid = 1'b1; i_data = 8'hE7;
    @(negedge clk);
    i_valid = 1'b0;
    check("race_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    check("race_rsp_err",   {31'b0, o_rsp_err},   32'd0);
    check("race_rsp_data",  {24'b0, o_rsp_data},  32'hE7);
    @(negedge clk);

    // Illegal opcode: accepted, nothing sent
    send_req(3'd6, 32'hA0B0_C0D0, 8'h00);
    check("illegal_valid", {31'b0, o_valid},     32'd0);
    check("illegal_ready", {31'b0, o_req_ready}, 32'd1);
    @(negedge clk);
    check_idle_rsp("illegal");

    // Single-byte NOP and RST
    send_req(3'd0, 32'h0, 8'h00);
    stream("nop", 64'h00_00_00_00_00_00_00_00, 1, 4'b1111, 1'b1);
    send_req(3'd2, 32'h0, 8'h00);
    stream("rstop", 64'h02_00_00_00_00_00_00_00, 1, 4'b1111, 1'b1);

    // Reset after the third byte of a WRITE abandons it and clears the cache
    send_req(3'd4, 32'h1234_5678, 8'hAB);
    stream("wr_part", 64'h05_12_34_00_00_00_00_00, 3, 4'b1111, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid",     {31'b0, o_valid},     32'd0);
    check("abort_req_ready", {31'b0, o_req_ready}, 32'd1);
    send_req(3'd4, 32'h1234_5678, 8'hAB);
    stream("wr_resend", 64'h05_12_34_06_56_78_04_AB, 8, 4'b1111, 1'b1);

    // BOOT is terminal until reset
    send_req(3'd1, 32'h0, 8'h00);
    stream("boot", 64'h01_00_00_00_00_00_00_00, 1, 4'b1111, 1'b1);
    i_req_valid = 1'b1; i_req_op = 3'd0; i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("boot_booted",    {31'b0, o_booted},    32'd1);
      check("boot_req_ready", {31'b0, o_req_ready}, 32'd0);
      check("boot_valid",     {31'b0, o_valid},     32'd0);
      check("boot_in_ready",  {31'b0, o_in_ready},  32'd0);
      @(negedge clk);
    end
    i_req_valid = 1'b0; i_valid = 1'b0;
    check_idle_rsp("boot");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("boot_rst_booted", {31'b0, o_booted},    32'd0);
    check("boot_rst_ready",  {31'b0, o_req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bios_link_master.md
BIOS_LINK_MASTER -- requirements
Module: bios_link_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: WAIT_RSP cycles before a read aborts.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_req_valid  in  1  host request present.
REQ-006 o_req_ready  out  1  request accepted when high with i_req_valid.
REQ-007 i_req_op  in  3  0 NOP, 1 BOOT, 2 RST, 3 READ, 4 WRITE; 5-7 illegal.
REQ-008 i_req_addr  in  32  RAM byte address (READ/WRITE only).
REQ-009 i_req_data  in  8  write byte (WRITE only).
REQ-010 o_data / o_valid / i_out_ready  out 8 / out 1 / in 1  command byte stream toward the BIOS.
REQ-011 i_data / i_valid / o_in_ready  in 8 / in 1 / out 1  response byte stream from the BIOS.
REQ-012 o_rsp_valid / o_rsp_data / o_rsp_err  out 1 / out 8 / out 1  read completion, one-cycle pulse.
REQ-013 o_booted  out  1  BOOT sent; link handed to run mode.

Function
REQ-014 Opcode bytes: NOP 0x00, BOOT 0x01, RST 0x02, READ 0x03, WRITE 0x04, ADR_LOWER 0x05, ADR_UPPER 0x06.
REQ-015 ADR_LOWER args = addr[31:24], addr[23:16]; ADR_UPPER args = addr[15:8], addr[7:0]; first arg sent first.
REQ-016 States: IDLE, SEND, WAIT_RSP, BOOTED; o_req_ready = (state==IDLE).
REQ-017 On accept: build an 8-entry byte buffer plus 4-bit count, enter SEND.
REQ-018 Address cache: hi_valid/hi[15:0] for addr[31:16], lo_valid/lo[15:0] for addr[15:0], all cleared by rst.
REQ-019 READ/WRITE: emit 0x05,hi,hi only if !hi_valid or addr[31:16] differs; then 0x06,lo,lo only if !lo_valid or addr[15:0] differs; then the op.
REQ-020 WRITE op bytes = 0x04, data (8 bytes max); READ op byte = 0x03.
REQ-021 NOP/BOOT/RST: single opcode byte; cache untouched.
REQ-022 Cache fields update at request accept.
REQ-023 Illegal op: accepted, no bytes, no response, stay IDLE.
REQ-024 SEND: o_valid=1, o_data=buffer[idx]; idx advances only on o_valid & i_out_ready.
REQ-025 o_data stable while o_valid & !i_out_ready.
REQ-026 After the last byte handshake: READ -> WAIT_RSP with timer cleared; BOOT -> BOOTED; else -> IDLE, next cycle.
REQ-027 WAIT_RSP: o_in_ready=1; on i_valid, o_rsp_valid=1 next cycle, o_rsp_data=i_data, o_rsp_err=0; -> IDLE.
REQ-028 WAIT_RSP timer increments each cycle; at TIMEOUT_CYCLES-1 with no i_valid: o_rsp_valid=1, o_rsp_err=1, o_rsp_data=0x00, clear both cache valids, -> IDLE.
REQ-029 Same-cycle i_valid and timeout expiry: the byte wins, err=0.
REQ-030 o_in_ready=0 outside WAIT_RSP; stray input bytes neither consumed nor reported.
REQ-031 BOOTED is terminal until rst: o_booted=1, o_req_ready=0, o_valid=0, o_in_ready=0.
REQ-032 o_rsp_valid, o_rsp_err, o_rsp_data held 0 except during the completion pulse.

Reset
REQ-033 rst (any state, including mid-SEND or WAIT_RSP) -> IDLE next edge; o_valid, o_in_ready, o_rsp_valid, o_rsp_err, o_booted = 0; o_rsp_data = 0x00; o_req_ready = 1; cache valids, idx, count, timer = 0.
REQ-034 A partially sent command is abandoned, not resumed.

Verification
REQ-035 After rst, WRITE addr 0x12345678 data 0xAB, i_out_ready=1 -> bytes 05 12 34 06 56 78 04 AB on consecutive cycles, then IDLE.
REQ-036 Then WRITE 0x12345679 data 0xCD -> 06 56 79 04 CD only; then READ 0x12345679 -> 03 only; i_data=0x5A on cycle 3 of WAIT_RSP -> o_rsp_valid pulse, data 0x5A, err 0.
REQ-037 i_out_ready toggled 1,0,0,1 during SEND -> no byte dropped or duplicated; o_data constant during stalls.
REQ-038 READ with TIMEOUT_CYCLES=16, no i_valid -> o_rsp_valid with err=1, data 0x00, 16 cycles after WAIT_RSP entry; next READ re-sends 05 and 06 prefixes.
REQ-039 BOOT -> single 0x01, then o_booted=1, o_req_ready=0 indefinitely; rst -> IDLE, o_booted=0.
REQ-040 rst asserted after the 3rd byte of a WRITE -> o_valid=0 next cycle; following WRITE to same address re-sends full 8-byte sequence.
